// File: rtl/axi_arb_pkg.sv
// Shared encodings for the AXI3 N-to-1 master arbiter: FSM states, burst types
// and the packed {lock,cache,prot} attribute width.
package axi_arb_pkg;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {BURST_FIXED = 2'd0, BURST_INCR = 2'd1, BURST_WRAP = 2'd2} burst_e;

  localparam int ATTR_W = 9;

endpackage

// File: rtl/arb_rr.sv
// Request arbiter for one AXI direction. With AXI_ARB_RR_EN defined it is a
// round-robin search starting at an internal pointer; otherwise lowest index wins.
module arb_rr #(
  parameter int N  = 2,
  parameter int IW = 1
) (
`ifdef AXI_ARB_RR_EN
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv,
  input  logic [IW-1:0] win,
`endif
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

`ifdef AXI_ARB_RR_EN
  logic [IW-1:0] ptr;

  // Pointer moves just past the master whose transaction just completed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ptr <= '0;
    else if (adv) ptr <= (win == IW'(N-1)) ? '0 : win + 1'b1;
  end

  always_comb begin
    logic found;
    found   = 1'b0;
    gnt     = '0;
    gnt_idx = '0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IW'(idx);
      end
    end
  end
`else
  always_comb begin
    logic found;
    found   = 1'b0;
    gnt     = '0;
    gnt_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[k]) begin
        found   = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = IW'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/axi_mst_arbiter.sv
// AXI3 N-to-1 master arbiter, one outstanding transaction per direction.
// Build option: AXI_ARB_RR_EN selects round-robin instead of fixed priority.
module axi_mst_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ID_W        = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [NUM_MASTERS*ID_W-1:0]       s_arid,
  input  logic [NUM_MASTERS*ADDR_W-1:0]     s_araddr,
  input  logic [NUM_MASTERS*4-1:0]          s_arlen,
  input  logic [NUM_MASTERS*3-1:0]          s_arsize,
  input  logic [NUM_MASTERS*2-1:0]          s_arburst,
  input  logic [NUM_MASTERS*ATTR_W-1:0]     s_arattr,
  input  logic [NUM_MASTERS-1:0]            s_arvalid,
  output logic [NUM_MASTERS-1:0]            s_arready,
  output logic [NUM_MASTERS*ID_W-1:0]       s_rid,
  output logic [NUM_MASTERS*DATA_W-1:0]     s_rdata,
  output logic [NUM_MASTERS*2-1:0]          s_rresp,
  output logic [NUM_MASTERS-1:0]            s_rlast,
  output logic [NUM_MASTERS-1:0]            s_rvalid,
  input  logic [NUM_MASTERS-1:0]            s_rready,
  input  logic [NUM_MASTERS*ID_W-1:0]       s_awid,
  input  logic [NUM_MASTERS*ADDR_W-1:0]     s_awaddr,
  input  logic [NUM_MASTERS*4-1:0]          s_awlen,
  input  logic [NUM_MASTERS*3-1:0]          s_awsize,
  input  logic [NUM_MASTERS*2-1:0]          s_awburst,
  input  logic [NUM_MASTERS*ATTR_W-1:0]     s_awattr,
  input  logic [NUM_MASTERS-1:0]            s_awvalid,
  output logic [NUM_MASTERS-1:0]            s_awready,
  input  logic [NUM_MASTERS*ID_W-1:0]       s_wid,
  input  logic [NUM_MASTERS*DATA_W-1:0]     s_wdata,
  input  logic [NUM_MASTERS*DATA_W/8-1:0]   s_wstrb,
  input  logic [NUM_MASTERS-1:0]            s_wlast,
  input  logic [NUM_MASTERS-1:0]            s_wvalid,
  output logic [NUM_MASTERS-1:0]            s_wready,
  output logic [NUM_MASTERS*ID_W-1:0]       s_bid,
  output logic [NUM_MASTERS*2-1:0]          s_bresp,
  output logic [NUM_MASTERS-1:0]            s_bvalid,
  input  logic [NUM_MASTERS-1:0]            s_bready,
  output logic [ID_W-1:0]                   m_arid,
  output logic [ADDR_W-1:0]                 m_araddr,
  output logic [3:0]                        m_arlen,
  output logic [2:0]                        m_arsize,
  output logic [1:0]                        m_arburst,
  output logic [ATTR_W-1:0]                 m_arattr,
  output logic                              m_arvalid,
  input  logic                              m_arready,
  input  logic [ID_W-1:0]                   m_rid,
  input  logic [DATA_W-1:0]                 m_rdata,
  input  logic [1:0]                        m_rresp,
  input  logic                              m_rlast,
  input  logic                              m_rvalid,
  output logic                              m_rready,
  output logic [ID_W-1:0]                   m_awid,
  output logic [ADDR_W-1:0]                 m_awaddr,
  output logic [3:0]                        m_awlen,
  output logic [2:0]                        m_awsize,
  output logic [1:0]                        m_awburst,
  output logic [ATTR_W-1:0]                 m_awattr,
  output logic                              m_awvalid,
  input  logic                              m_awready,
  output logic [ID_W-1:0]                   m_wid,
  output logic [DATA_W-1:0]                 m_wdata,
  output logic [DATA_W/8-1:0]               m_wstrb,
  output logic                              m_wlast,
  output logic                              m_wvalid,
  input  logic                              m_wready,
  input  logic [ID_W-1:0]                   m_bid,
  input  logic [1:0]                        m_bresp,
  input  logic                              m_bvalid,
  output logic                              m_bready
);

  localparam int N  = NUM_MASTERS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = DATA_W / 8;

  r_state_e      r_st, r_nxt;
  w_state_e      w_st, w_nxt;
  logic [IW-1:0] r_g, w_g, ar_idx, aw_idx;
  logic [N-1:0]  ar_gnt, aw_gnt;
  logic          r_done, w_done;

  assign r_done = (r_st == R_DATA) && m_rvalid && s_rready[r_g] && m_rlast;
  assign w_done = (w_st == W_RESP) && m_bvalid && s_bready[w_g];

  arb_rr #(.N(N), .IW(IW)) u_ar_arb (
`ifdef AXI_ARB_RR_EN
    .clk(aclk), .rst_n(aresetn), .adv(r_done), .win(r_g),
`endif
    .req(s_arvalid), .gnt(ar_gnt), .gnt_idx(ar_idx)
  );

  arb_rr #(.N(N), .IW(IW)) u_aw_arb (
`ifdef AXI_ARB_RR_EN
    .clk(aclk), .rst_n(aresetn), .adv(w_done), .win(w_g),
`endif
    .req(s_awvalid), .gnt(aw_gnt), .gnt_idx(aw_idx)
  );

  // Grant is captured once in IDLE and held to the end of the transaction.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_st <= R_IDLE;
      w_st <= W_IDLE;
      r_g  <= '0;
      w_g  <= '0;
    end else begin
      r_st <= r_nxt;
      w_st <= w_nxt;
      if (r_st == R_IDLE && |ar_gnt) r_g <= ar_idx;
      if (w_st == W_IDLE && |aw_gnt) w_g <= aw_idx;
    end
  end

  always_comb begin
    r_nxt     = r_st;
    m_arid    = '0;
    m_araddr  = '0;
    m_arlen   = '0;
    m_arsize  = '0;
    m_arburst = '0;
    m_arattr  = '0;
    m_arvalid = 1'b0;
    s_arready = '0;
    s_rid     = '0;
    s_rdata   = '0;
    s_rresp   = '0;
    s_rlast   = '0;
    s_rvalid  = '0;
    m_rready  = 1'b0;
    case (r_st)
      R_IDLE: if (|ar_gnt) r_nxt = R_ADDR;
      R_ADDR: begin
        m_arid         = s_arid[r_g*ID_W +: ID_W];
        m_araddr       = s_araddr[r_g*ADDR_W +: ADDR_W];
        m_arlen        = s_arlen[r_g*4 +: 4];
        m_arsize       = s_arsize[r_g*3 +: 3];
        m_arburst      = s_arburst[r_g*2 +: 2];
        m_arattr       = s_arattr[r_g*ATTR_W +: ATTR_W];
        m_arvalid      = s_arvalid[r_g];
        s_arready[r_g] = m_arready;
        if (s_arvalid[r_g] && m_arready) r_nxt = R_DATA;
      end
      R_DATA: begin
        // Payload goes to everyone; only the granted slice sees valid.
        s_rid         = {N{m_rid}};
        s_rdata       = {N{m_rdata}};
        s_rresp       = {N{m_rresp}};
        s_rlast       = {N{m_rlast}};
        s_rvalid[r_g] = m_rvalid;
        m_rready      = s_rready[r_g];
        if (r_done) r_nxt = R_IDLE;
      end
      default: r_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_nxt     = w_st;
    m_awid    = '0;
    m_awaddr  = '0;
    m_awlen   = '0;
    m_awsize  = '0;
    m_awburst = '0;
    m_awattr  = '0;
    m_awvalid = 1'b0;
    s_awready = '0;
    m_wid     = '0;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_wlast   = 1'b0;
    m_wvalid  = 1'b0;
    s_wready  = '0;
    s_bid     = '0;
    s_bresp   = '0;
    s_bvalid  = '0;
    m_bready  = 1'b0;
    case (w_st)
      W_IDLE: if (|aw_gnt) w_nxt = W_ADDR;
      W_ADDR: begin
        m_awid         = s_awid[w_g*ID_W +: ID_W];
        m_awaddr       = s_awaddr[w_g*ADDR_W +: ADDR_W];
        m_awlen        = s_awlen[w_g*4 +: 4];
        m_awsize       = s_awsize[w_g*3 +: 3];
        m_awburst      = s_awburst[w_g*2 +: 2];
        m_awattr       = s_awattr[w_g*ATTR_W +: ATTR_W];
        m_awvalid      = s_awvalid[w_g];
        s_awready[w_g] = m_awready;
        if (s_awvalid[w_g] && m_awready) w_nxt = W_DATA;
      end
      W_DATA: begin
        m_wid         = s_wid[w_g*ID_W +: ID_W];
        m_wdata       = s_wdata[w_g*DATA_W +: DATA_W];
        m_wstrb       = s_wstrb[w_g*SW +: SW];
        m_wlast       = s_wlast[w_g];
        m_wvalid      = s_wvalid[w_g];
        s_wready[w_g] = m_wready;
        if (s_wvalid[w_g] && m_wready && s_wlast[w_g]) w_nxt = W_RESP;
      end
      W_RESP: begin
        s_bid         = {N{m_bid}};
        s_bresp       = {N{m_bresp}};
        s_bvalid[w_g] = m_bvalid;
        m_bready      = s_bready[w_g];
        if (w_done) w_nxt = W_IDLE;
      end
      default: w_nxt = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_mst_arbiter.sv
// Directed bench for axi_mst_arbiter with two masters and hand-computed expectations.
module tb_axi_mst_arbiter;
  import axi_arb_pkg::*;

  localparam int N = 2;

  logic aclk = 1'b0;
  logic aresetn;
  logic [N*4-1:0]      s_arid, s_arlen, s_awid, s_awlen, s_wid, s_wstrb, s_rid, s_bid;
  logic [N*32-1:0]     s_araddr, s_awaddr, s_wdata, s_rdata;
  logic [N*3-1:0]      s_arsize, s_awsize;
  logic [N*2-1:0]      s_arburst, s_awburst, s_rresp, s_bresp;
  logic [N*ATTR_W-1:0] s_arattr, s_awattr;
  logic [N-1:0]        s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic [N-1:0]        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [3:0]  m_arid, m_arlen, m_rid, m_awid, m_awlen, m_wid, m_wstrb, m_bid;
  logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
  logic [2:0]  m_arsize, m_awsize;
  logic [1:0]  m_arburst, m_rresp, m_awburst, m_bresp;
  logic [ATTR_W-1:0] m_arattr, m_awattr;
  logic m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;

  int total = 0;
  int bad   = 0;

  axi_mst_arbiter #(.NUM_MASTERS(N), .ID_W(4), .ADDR_W(32), .DATA_W(32)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arattr(s_arattr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awattr(s_awattr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wid(s_wid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arattr(m_arattr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awattr(m_awattr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units past the next rising edge.
  task automatic cyc();
    @(posedge aclk);
    #2;
  endtask

  task automatic set_ar(input int i, input logic [31:0] a, input logic [3:0] l);
    s_araddr[i*32 +: 32] = a;
    s_arlen[i*4 +: 4]    = l;
    s_arsize[i*3 +: 3]   = 3'd2;
    s_arburst[i*2 +: 2]  = BURST_INCR;
  endtask

  initial begin
    s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0; s_arattr = '0;
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awattr = '0;
    s_wid = '0; s_wdata = '0; s_wstrb = '0; s_wlast = '0;
    m_rid = '0; m_rresp = '0; m_rlast = 1'b0; m_bid = '0; m_bresp = '0;
    // Reset held while every upstream/downstream handshake input is active.
    aresetn = 1'b0;
    s_arvalid = '1; s_awvalid = '1; s_wvalid = '1; s_rready = '1; s_bready = '1;
    m_arready = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
    m_rvalid = 1'b1; m_rdata = 32'h1234_5678; m_bvalid = 1'b1;
    #1;
    chk("rst_m_arvalid", m_arvalid, 0);
    chk("rst_s_arready", s_arready, 0);
    chk("rst_s_rvalid",  s_rvalid, 0);
    chk("rst_s_rdata",   s_rdata, 0);
    chk("rst_m_araddr",  m_araddr, 0);
    chk("rst_s_wready",  s_wready, 0);
    chk("rst_s_bvalid",  s_bvalid, 0);
    chk("rst_m_rready",  m_rready, 0);
    s_arvalid = '0; s_awvalid = '0; s_wvalid = '0; s_rready = '0; s_bready = '0;
    m_arready = 1'b0; m_awready = 1'b0; m_wready = 1'b0; m_rvalid = 1'b0; m_bvalid = 1'b0;
    cyc(); cyc();
    aresetn = 1'b1;
    cyc();

    // Single read from master 1.
    set_ar(1, 32'hBFC0_0000, 4'd0); s_arvalid = 2'b10; m_arready = 1'b0;
    #1 chk("t1_idle_arvalid", m_arvalid, 0);
    cyc();
    #1 chk("t1_arvalid", m_arvalid, 1);
    chk("t1_araddr", m_araddr, 32'hBFC0_0000);
    chk("t1_arready_hold", s_arready, 2'b00);
    m_arready = 1'b1;
    #1 chk("t1_arready", s_arready, 2'b10);
    cyc();
    s_arvalid = '0; m_arready = 1'b0; s_rready = 2'b11;
    m_rvalid = 1'b1; m_rdata = 32'h3C1D_BFC0; m_rlast = 1'b1;
    #1 chk("t1_rvalid", s_rvalid, 2'b10);
    chk("t1_rdata", s_rdata[63:32], 32'h3C1D_BFC0);
    chk("t1_arvalid_off", m_arvalid, 0);
    cyc();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1 chk("t1_done", s_rvalid, 2'b00);

    // Simultaneous 4-beat reads: master 0 first, no interleaving.
    set_ar(0, 32'h0000_1000, 4'd3); set_ar(1, 32'h0000_2000, 4'd3);
    s_arvalid = 2'b11; m_arready = 1'b1;
    cyc();
    #1 chk("t2_addr0", m_araddr, 32'h0000_1000);
    chk("t2_len0", m_arlen, 4'd3);
    chk("t2_arready0", s_arready, 2'b01);
    cyc();
    s_arvalid = 2'b10;
    for (int b = 0; b < 4; b++) begin
      m_rvalid = 1'b1; m_rdata = 32'hA0 + b; m_rlast = (b == 3);
      #1 chk("t2_m0_rvalid", s_rvalid, 2'b01);
      chk("t2_m0_rdata", s_rdata[31:0], 32'hA0 + b);
      chk("t2_no_ar", m_arvalid, 0);
      cyc();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1 chk("t2_gap", s_rvalid, 2'b00);
    cyc();
    #1 chk("t2_addr1", m_araddr, 32'h0000_2000);
    chk("t2_arready1", s_arready, 2'b10);
    cyc();
    s_arvalid = '0; m_arready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      m_rvalid = 1'b1; m_rdata = 32'hB0 + b; m_rlast = (b == 3);
      #1 chk("t2_m1_rvalid", s_rvalid, 2'b10);
      chk("t2_m1_rdata", s_rdata[63:32], 32'hB0 + b);
      cyc();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;

    // Concurrent read (master 1) and write (master 0, W offered before AW).
    set_ar(1, 32'h0000_3000, 4'd1); s_arvalid = 2'b10; m_arready = 1'b1;
    s_awaddr[31:0] = 32'h8000_1000; s_awlen[3:0] = 4'd0; s_awvalid = 2'b01;
    s_wdata[31:0] = 32'hDEAD_BEEF; s_wstrb[3:0] = 4'hF; s_wlast = 2'b01; s_wvalid = 2'b01;
    m_awready = 1'b0; m_wready = 1'b1; s_bready = 2'b11;
    #1 chk("t3_w_early", s_wready, 2'b00);
    cyc();
    #1 chk("t3_awvalid", m_awvalid, 1);
    chk("t3_awaddr", m_awaddr, 32'h8000_1000);
    chk("t3_w_held", s_wready, 2'b00);
    chk("t3_m_wvalid_held", m_wvalid, 0);
    chk("t3_arready", s_arready, 2'b10);
    m_awready = 1'b1;
    cyc();
    s_arvalid = '0; s_awvalid = '0; m_awready = 1'b0; m_arready = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'hC0; m_rlast = 1'b0;
    #1 chk("t3_wvalid", m_wvalid, 1);
    chk("t3_wdata", m_wdata, 32'hDEAD_BEEF);
    chk("t3_wstrb", m_wstrb, 4'hF);
    chk("t3_wready", s_wready, 2'b01);
    chk("t3_rvalid_overlap", s_rvalid, 2'b10);
    cyc();
    s_wvalid = '0; s_wlast = '0;
    m_rdata = 32'hC1; m_rlast = 1'b1; m_bvalid = 1'b1; m_bresp = 2'b00;
    #1 chk("t3_bvalid", s_bvalid, 2'b01);
    chk("t3_bresp", s_bresp[1:0], 2'b00);
    chk("t3_bready", m_bready, 1);
    chk("t3_rdata1", s_rdata[63:32], 32'hC1);
    chk("t3_rvalid1", s_rvalid, 2'b10);
    cyc();
    m_rvalid = 1'b0; m_rlast = 1'b0; m_bvalid = 1'b0; m_wready = 1'b0;
    #1 chk("t3_b_done", s_bvalid, 2'b00);

    // Address backpressure then per-beat rready toggling.
    set_ar(0, 32'h0000_4000, 4'd2); s_arvalid = 2'b01; m_arready = 1'b0;
    cyc();
    set_ar(1, 32'h0000_5000, 4'd0); s_arvalid = 2'b11;
    for (int c = 0; c < 5; c++) begin
      #1 chk("t4_ar_hold", m_araddr, 32'h0000_4000);
      chk("t4_arready0", s_arready, 2'b00);
      cyc();
    end
    m_arready = 1'b1;
    cyc();
    s_arvalid = 2'b10; m_arready = 1'b0; m_rvalid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      m_rdata = 32'hD0 + b; m_rlast = (b == 2); s_rready = 2'b10;
      #1 chk("t4_rready_lo", m_rready, 0);
      chk("t4_rdata", s_rdata[31:0], 32'hD0 + b);
      cyc();
      s_rready = 2'b11;
      #1 chk("t4_rready_hi", m_rready, 1);
      chk("t4_rvalid", s_rvalid, 2'b01);
      cyc();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    cyc();
    #1 chk("t4_next_grant", m_araddr, 32'h0000_5000);
    m_arready = 1'b1;
    cyc();
    s_arvalid = '0; m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hE0; m_rlast = 1'b1;
    #1 chk("t4_m1_rvalid", s_rvalid, 2'b10);
    cyc();
    m_rvalid = 1'b0; m_rlast = 1'b0;

    // Master 0 keeps requesting: fixed priority keeps winning with master 0.
    set_ar(0, 32'h0000_6000, 4'd0); set_ar(1, 32'h0000_7000, 4'd0);
    s_arvalid = 2'b11; m_arready = 1'b1;
    cyc();
    #1 chk("t5_first", m_araddr, 32'h0000_6000);
    cyc();
    m_rvalid = 1'b1; m_rlast = 1'b1;
    cyc();
    m_rvalid = 1'b0;
    cyc();
`ifdef AXI_ARB_RR_EN
    #1 chk("t5_second", m_araddr, 32'h0000_7000);
`else
    #1 chk("t5_second", m_araddr, 32'h0000_6000);
`endif
    cyc();
    m_rvalid = 1'b1; s_arvalid = 2'b10;
    cyc();
    m_rvalid = 1'b0;
    cyc();
    #1 chk("t5_third", m_araddr, 32'h0000_7000);
    cyc();
    s_arvalid = '0; m_arready = 1'b0; m_rvalid = 1'b1;
    cyc();
    m_rvalid = 1'b0; m_rlast = 1'b0;

    // Reset during beat 2 of a 4-beat burst.
    set_ar(0, 32'h0000_8000, 4'd3); s_arvalid = 2'b01; m_arready = 1'b1;
    cyc(); cyc();
    s_arvalid = '0; m_arready = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b0;
    m_rdata = 32'hF0; cyc();
    m_rdata = 32'hF1; cyc();
    m_rdata = 32'hF2;
    #1 chk("t6_beat2", s_rvalid, 2'b01);
    aresetn = 1'b0;
    #1 chk("t6_rst_rvalid", s_rvalid, 2'b00);
    chk("t6_rst_rready", m_rready, 0);
    chk("t6_rst_rdata", s_rdata, 0);
    cyc();
    aresetn = 1'b1; m_rvalid = 1'b0;
    set_ar(1, 32'h0000_9000, 4'd0); s_arvalid = 2'b10;
    #1 chk("t6_idle", m_arvalid, 0);
    cyc();
    #1 chk("t6_arvalid", m_arvalid, 1);
    chk("t6_araddr", m_araddr, 32'h0000_9000);
    m_arready = 1'b1;
    cyc();
    s_arvalid = '0; m_arready = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = 32'h99;
    #1 chk("t6_rvalid", s_rvalid, 2'b10);
    cyc();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1 chk("t6_done", s_rvalid, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
